// File: rtl/tusca_uc.sv
// tusca_uc: main control unit for the TUSCA datapath.
// Sequences measure -> transmit -> delay, services configuration requests,
// supervises handshakes with a watchdog and counts consecutive failures.
module tusca_uc #(
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
  parameter int unsigned MAX_ERROS      = 3,
  parameter int unsigned W_TIMEOUT      = $clog2(TIMEOUT_CICLOS + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pedido_config,
  input  logic       oscilar,
  input  logic       fim_delay,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic       pronto_config,
  input  logic       erro_config,
  input  logic       pronto_transmite_medida,
  output logic       medir_dht11,
  output logic       receber_config,
  output logic       transmite_medida,
  output logic       conta_delay,
  output logic       zera_delay,
  output logic       gira,
  output logic       falha,
  output logic       config_invalida,
  output logic [1:0] db_erros,
  output logic [3:0] db_estado
);

  localparam logic [3:0] S_INICIAL        = 4'd0;
  localparam logic [3:0] S_PREPARACAO     = 4'd1;
  localparam logic [3:0] S_MEDIR          = 4'd2;
  localparam logic [3:0] S_AGUARDA_MEDIDA = 4'd3;
  localparam logic [3:0] S_TRANSMITE      = 4'd4;
  localparam logic [3:0] S_AGUARDA_TX     = 4'd5;
  localparam logic [3:0] S_ESPERA         = 4'd6;
  localparam logic [3:0] S_CONFIG         = 4'd7;
  localparam logic [3:0] S_AGUARDA_CONFIG = 4'd8;
  localparam logic [3:0] S_ERRO           = 4'd9;
  localparam logic [3:0] S_FALHA          = 4'd15;

  localparam logic [W_TIMEOUT-1:0] WD_LIMIT = W_TIMEOUT'(TIMEOUT_CICLOS - 1);
  localparam logic [W_TIMEOUT-1:0] WD_MAX   = '1;
  localparam logic [1:0]           ERR_MAX  = 2'(MAX_ERROS);

  logic [3:0]           state_q, state_d;
  logic [W_TIMEOUT-1:0] wd_q, wd_d;
  logic [1:0]           erros_q, erros_d;
  logic                 cfg_inv_q, cfg_inv_d;
  logic                 wd_expired;

  // Watchdog has reached its limit (it saturates, so >= is safe)
  assign wd_expired = (wd_q >= WD_LIMIT);

  // State, watchdog, error counter and config status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INICIAL;
      wd_q      <= '0;
      erros_q   <= '0;
      cfg_inv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      erros_q   <= erros_d;
      cfg_inv_q <= cfg_inv_d;
    end
  end

  // Next-state logic; ligar=0 overrides everything and aborts handshakes
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    erros_d   = erros_q;
    cfg_inv_d = cfg_inv_q;

    if (!ligar && (state_q != S_INICIAL)) begin
      state_d = S_INICIAL;
      if (state_q == S_FALHA) erros_d = '0;
    end else begin
      case (state_q)
        S_INICIAL:    if (ligar) state_d = S_PREPARACAO;
        S_PREPARACAO: state_d = S_MEDIR;
        S_MEDIR: begin
          wd_d    = '0;
          state_d = S_AGUARDA_MEDIDA;
        end
        S_AGUARDA_MEDIDA: begin
          if (wd_q != WD_MAX) wd_d = wd_q + W_TIMEOUT'(1);
          // error beats a simultaneous valid pulse
          if (erro_medida || wd_expired) begin
            state_d = S_ERRO;
          end else if (pronto_medida) begin
            erros_d = '0;
            state_d = S_TRANSMITE;
          end
        end
        S_ERRO: begin
          erros_d = (erros_q == 2'd3) ? 2'd3 : erros_q + 2'd1;
          state_d = (erros_d == ERR_MAX) ? S_FALHA : S_ESPERA;
        end
        S_TRANSMITE:  state_d = S_AGUARDA_TX;
        S_AGUARDA_TX: if (pronto_transmite_medida) state_d = S_ESPERA;
        S_ESPERA: begin
          if (pedido_config)  state_d = S_CONFIG;
          else if (fim_delay) state_d = S_PREPARACAO;
        end
        S_CONFIG: begin
          wd_d    = '0;
          state_d = S_AGUARDA_CONFIG;
        end
        S_AGUARDA_CONFIG: begin
          if (wd_q != WD_MAX) wd_d = wd_q + W_TIMEOUT'(1);
          if (erro_config || wd_expired) begin
            cfg_inv_d = 1'b1;
            state_d   = S_PREPARACAO;
          end else if (pronto_config) begin
            cfg_inv_d = 1'b0;
            state_d   = S_PREPARACAO;
          end
        end
        S_FALHA: state_d = S_FALHA;
        default: state_d = S_INICIAL;
      endcase
    end
  end

  // Moore output decode from the state register
  always_comb begin
    medir_dht11      = (state_q == S_MEDIR);
    receber_config   = (state_q == S_CONFIG);
    transmite_medida = (state_q == S_TRANSMITE);
    conta_delay      = (state_q == S_ESPERA);
    zera_delay       = (state_q == S_PREPARACAO);
    gira             = (state_q == S_ESPERA) && oscilar;
    falha            = (state_q == S_FALHA);
    config_invalida  = cfg_inv_q;
    db_erros         = erros_q;
    db_estado        = state_q;
  end

endmodule

// File: tb/tb_tusca_uc.sv
// Directed testbench for tusca_uc with a short watchdog limit.
module tb_tusca_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar, pedido_config, oscilar, fim_delay;
  logic       pronto_medida, erro_medida, pronto_config, erro_config;
  logic       pronto_transmite_medida;
  logic       medir_dht11, receber_config, transmite_medida;
  logic       conta_delay, zera_delay, gira, falha, config_invalida;
  logic [1:0] db_erros;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int n;

  tusca_uc #(.TIMEOUT_CICLOS(16), .MAX_ERROS(3)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pedido_config(pedido_config),
    .oscilar(oscilar), .fim_delay(fim_delay), .pronto_medida(pronto_medida),
    .erro_medida(erro_medida), .pronto_config(pronto_config),
    .erro_config(erro_config), .pronto_transmite_medida(pronto_transmite_medida),
    .medir_dht11(medir_dht11), .receber_config(receber_config),
    .transmite_medida(transmite_medida), .conta_delay(conta_delay),
    .zera_delay(zera_delay), .gira(gira), .falha(falha),
    .config_invalida(config_invalida), .db_erros(db_erros), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_pm();
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
  endtask

  task automatic pulse_ptx();
    pronto_transmite_medida = 1'b1; tick(); pronto_transmite_medida = 1'b0;
  endtask

  task automatic pulse_pedido();
    pedido_config = 1'b1; tick(); pedido_config = 1'b0;
  endtask

  // From preparacao, run a successful measurement + transmission into espera
  task automatic to_espera();
    tick(); tick(); pulse_pm();
    chk("to_espera_tx", 32'(db_estado), 32'd4);
    tick();
    chk("gira_aguarda_tx", 32'(gira), 32'd0);
    pulse_ptx();
    chk("to_espera", 32'(db_estado), 32'd6);
  endtask

  function automatic logic [6:0] outs();
    return {medir_dht11, receber_config, transmite_medida, conta_delay,
            zera_delay, gira, falha};
  endfunction

  initial begin
    reset = 1'b0; ligar = 1'b0; pedido_config = 1'b0; oscilar = 1'b0;
    fim_delay = 1'b0; pronto_medida = 1'b0; erro_medida = 1'b0;
    pronto_config = 1'b0; erro_config = 1'b0; pronto_transmite_medida = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", 32'(db_estado), 32'd0);
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_erros", 32'(db_erros), 32'd0);
    chk("rst_cfg", 32'(config_invalida), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_off", 32'(db_estado), 32'd0);

    // 1. Nominal cycle
    ligar = 1'b1;
    tick();
    chk("nom_prep", 32'(db_estado), 32'd1);
    chk("nom_zera", 32'(zera_delay), 32'd1);
    tick();
    chk("nom_medir", 32'(db_estado), 32'd2);
    chk("nom_medir_pulse", 32'(medir_dht11), 32'd1);
    tick();
    chk("nom_aguarda", 32'(db_estado), 32'd3);
    chk("nom_medir_low", 32'(medir_dht11), 32'd0);
    repeat (4) tick();
    chk("nom_still_wait", 32'(db_estado), 32'd3);
    pulse_pm();
    chk("nom_tx", 32'(db_estado), 32'd4);
    chk("nom_tx_pulse", 32'(transmite_medida), 32'd1);
    tick();
    chk("nom_aguarda_tx", 32'(db_estado), 32'd5);
    chk("nom_tx_low", 32'(transmite_medida), 32'd0);
    repeat (19) tick();
    chk("nom_no_tx_timeout", 32'(db_estado), 32'd5);
    pulse_ptx();
    chk("nom_espera", 32'(db_estado), 32'd6);
    chk("nom_conta", 32'(conta_delay), 32'd1);
    chk("nom_gira_off", 32'(gira), 32'd0);
    repeat (99) tick();
    chk("nom_espera_hold", 32'(db_estado), 32'd6);
    fim_delay = 1'b1; tick(); fim_delay = 1'b0;
    chk("nom_back_prep", 32'(db_estado), 32'd1);
    tick();
    chk("nom_back_medir", 32'(db_estado), 32'd2);
    tick();

    // 3. Watchdog: no response -> erro 16 cycles after entering aguarda_medida
    n = 0;
    while (db_estado == 4'd3 && n < 40) begin
      tick();
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd16);
    chk("wd_erro", 32'(db_estado), 32'd9);
    tick();
    chk("wd_espera", 32'(db_estado), 32'd6);
    chk("wd_erros1", 32'(db_erros), 32'd1);

    // 2. Consecutive measurement errors (simultaneous pulses: erro wins)
    fim_delay = 1'b1; tick(); fim_delay = 1'b0;
    tick(); tick();
    pronto_medida = 1'b1; erro_medida = 1'b1; tick();
    pronto_medida = 1'b0; erro_medida = 1'b0;
    chk("err_both_erro", 32'(db_estado), 32'd9);
    tick();
    chk("err_erros2", 32'(db_erros), 32'd2);
    chk("err_espera2", 32'(db_estado), 32'd6);
    fim_delay = 1'b1; tick(); fim_delay = 1'b0;
    tick(); tick();
    erro_medida = 1'b1; tick(); erro_medida = 1'b0;
    chk("err_erro3", 32'(db_estado), 32'd9);
    tick();
    chk("err_falha_state", 32'(db_estado), 32'd15);
    chk("err_falha_outs", 32'(outs()), 32'd1);
    chk("err_erros3", 32'(db_erros), 32'd3);
    pulse_pm();
    chk("err_falha_ignore", 32'(db_estado), 32'd15);
    ligar = 1'b0;
    tick();
    chk("err_exit_state", 32'(db_estado), 32'd0);
    chk("err_exit_falha", 32'(falha), 32'd0);
    chk("err_exit_erros", 32'(db_erros), 32'd0);

    // 4 + 6. Servo and config priority
    ligar = 1'b1;
    tick();
    oscilar = 1'b1;
    to_espera();
    chk("servo_on", 32'(gira), 32'd1);
    oscilar = 1'b0;
    tick();
    chk("servo_off", 32'(gira), 32'd0);
    pedido_config = 1'b1; fim_delay = 1'b1; tick();
    pedido_config = 1'b0; fim_delay = 1'b0;
    chk("cfg_priority", 32'(db_estado), 32'd7);
    chk("cfg_pulse", 32'(receber_config), 32'd1);
    tick();
    chk("cfg_aguarda", 32'(db_estado), 32'd8);
    chk("cfg_pulse_low", 32'(receber_config), 32'd0);
    erro_config = 1'b1; tick(); erro_config = 1'b0;
    chk("cfg_err_state", 32'(db_estado), 32'd1);
    chk("cfg_err_inv", 32'(config_invalida), 32'd1);
    to_espera();
    pulse_pedido();
    tick();
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    chk("cfg_ok_state", 32'(db_estado), 32'd1);
    chk("cfg_ok_inv", 32'(config_invalida), 32'd0);
    to_espera();
    pulse_pedido();
    tick();
    n = 0;
    while (db_estado == 4'd8 && n < 40) begin
      tick();
      n++;
    end
    chk("cfg_to_cycles", 32'(n), 32'd16);
    chk("cfg_to_state", 32'(db_estado), 32'd1);
    chk("cfg_to_inv", 32'(config_invalida), 32'd1);

    // 5. Abort during aguarda_transmissao, then async reset mid-espera
    tick(); tick(); pulse_pm(); tick();
    chk("abort_pre", 32'(db_estado), 32'd5);
    ligar = 1'b0;
    tick();
    chk("abort_state", 32'(db_estado), 32'd0);
    chk("abort_outs", 32'(outs()), 32'd0);
    chk("abort_cfg_kept", 32'(config_invalida), 32'd1);
    ligar = 1'b1;
    tick();
    to_espera();
    oscilar = 1'b1;
    #1;
    chk("pre_rst_gira", 32'(gira), 32'd1);
    chk("pre_rst_conta", 32'(conta_delay), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_conta", 32'(conta_delay), 32'd0);
    chk("async_rst_gira", 32'(gira), 32'd0);
    chk("async_rst_state", 32'(db_estado), 32'd0);
    chk("async_rst_cfg", 32'(config_invalida), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_prep", 32'(db_estado), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
